// File: rtl/vga_scan_timing_pkg.sv
// Shared VGA timing constants, coordinate widths and sync polarity for the
// scan generator and its sync delay line.
package vga_scan_timing_pkg;

    localparam int WIDTH_LOG2  = 10;
    localparam int HEIGHT_LOG2 = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam logic       SYNC_ACTIVE = 1'b0;
    localparam logic [1:0] SYNC_IDLE   = {2{~SYNC_ACTIVE}};

    // Sync level for a coordinate: active inside [start, start+width).
    function automatic logic sync_level(input int pos, input int start, input int width);
        return ((pos >= start) && (pos < start + width)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// Raster-scan output bundle from the timing generator to the renderer and VGA pins.
interface vga_scan_timing_if;

    // No backpressure: pixel_tick qualifies one pixel period; every other signal is
    // registered on the same edge and stays stable until the next tick.
    logic                                        pixel_tick;
    logic [vga_scan_timing_pkg::WIDTH_LOG2-1:0]  x;
    logic [vga_scan_timing_pkg::HEIGHT_LOG2-1:0] y;
    logic                                        toDisplay;
    logic                                        hsync;
    logic                                        vsync;
    logic                                        line_start;
    logic                                        frame_start;

    modport master (
        output pixel_tick, x, y, toDisplay, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input pixel_tick, x, y, toDisplay, hsync, vsync, line_start, frame_start
    );

endinterface

// File: rtl/vga_scan_timing_sync_delay_line.sv
// Pixel-tick shift register that lines {hsync, vsync} up with the renderer's
// registered colour output; resets to the idle (inactive) sync level.
module sync_delay_line
    import vga_scan_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    // stage[0] captures the raw value, so even DEPTH = 0 gives a registered output.
    logic [1:0] stage [DEPTH+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                stage[i] <= SYNC_IDLE;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i <= DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH];

endmodule

// File: rtl/vga_scan_timing.sv
// VGA raster scan: pixel-clock enable, x/y counters, visible flag, line/frame
// pulses and delayed active-low hsync/vsync.
module vga_scan_timing
    import vga_scan_timing_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int SYNC_DELAY = 2
) (
    input  logic                clk,
    input  logic                rst,
    vga_scan_timing_if.master   scan
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [WIDTH_LOG2-1:0]  X_LAST   = WIDTH_LOG2'(H_TOTAL - 1);
    localparam logic [WIDTH_LOG2-1:0]  X_VIS    = WIDTH_LOG2'(H_VISIBLE);
    localparam logic [HEIGHT_LOG2-1:0] Y_LAST   = HEIGHT_LOG2'(V_TOTAL - 1);
    localparam logic [HEIGHT_LOG2-1:0] Y_VIS    = HEIGHT_LOG2'(V_VISIBLE);

    if (CLK_DIV < 1 || SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_params
        $fatal(1, "vga_scan_timing: CLK_DIV must be >= 1 and SYNC_DELAY within 0..7");
    end
    if (H_TOTAL > (1 << WIDTH_LOG2) || V_TOTAL > (1 << HEIGHT_LOG2)) begin : g_bad_size
        $fatal(1, "vga_scan_timing: H_TOTAL/V_TOTAL do not fit the coordinate width");
    end

    logic [DIV_W-1:0]       div_cnt;
    logic                   div_term;
    logic [WIDTH_LOG2-1:0]  x_next;
    logic [HEIGHT_LOG2-1:0] y_next;
    logic [1:0]             sync_raw;
    logic [1:0]             sync_q;

    assign div_term = (div_cnt == DIV_LAST);

    // Coordinates the scan moves to on the next terminal count; every registered
    // output is derived from these so nothing skews against x/y.
    always_comb begin
        x_next = scan.x + 1'b1;
        y_next = scan.y;
        if (scan.x == X_LAST) begin
            x_next = '0;
            y_next = (scan.y == Y_LAST) ? '0 : scan.y + 1'b1;
        end
    end

    assign sync_raw = {sync_level(int'(x_next), H_VISIBLE + H_FRONT, H_SYNC),
                       sync_level(int'(y_next), V_VISIBLE + V_FRONT, V_SYNC)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt          <= '0;
            scan.pixel_tick  <= 1'b0;
            scan.x           <= X_LAST;
            scan.y           <= Y_LAST;
            scan.toDisplay   <= 1'b0;
            scan.line_start  <= 1'b0;
            scan.frame_start <= 1'b0;
        end else begin
            div_cnt          <= div_term ? '0 : div_cnt + 1'b1;
            scan.pixel_tick  <= div_term;
            scan.line_start  <= 1'b0;
            scan.frame_start <= 1'b0;
            if (div_term) begin
                scan.x           <= x_next;
                scan.y           <= y_next;
                scan.toDisplay   <= (x_next < X_VIS) && (y_next < Y_VIS);
                scan.line_start  <= (x_next == '0);
                scan.frame_start <= (x_next == '0) && (y_next == '0);
            end
        end
    end

    sync_delay_line #(
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (div_term),
        .din  (sync_raw),
        .dout (sync_q)
    );

    assign scan.hsync = sync_q[1];
    assign scan.vsync = sync_q[0];

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
Generates the VGA raster scan that drives the pixel renderer: pixel-clock enable, pixel coordinates x/y and the visible-area flag toDisplay.
Also produces hsync/vsync, delayed to line up with the renderer's registered r/g/b output, plus frame and line start pulses for game logic.
Sits between the board clock and the renderer; the renderer consumes x, y and toDisplay, and hsync/vsync go straight to the VGA connector.

Parameters:
CLK_DIV, 4, board clocks per pixel (100 MHz -> 25 MHz); legal range >= 1
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch in pixels
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 48, horizontal back porch in pixels
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch in lines
SYNC_DELAY, 2, pixel ticks of delay applied to hsync/vsync; legal range 0..7

Ports:
clk  in  1  board clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
pixel_tick  out  1  one-clk pulse per pixel period
x  out  `width_log2  current column (0..H_TOTAL-1)
y  out  `height_log2  current line (0..V_TOTAL-1)
toDisplay  out  1  high when x < H_VISIBLE and y < V_VISIBLE
hsync  out  1  active-low horizontal sync, delayed by SYNC_DELAY ticks
vsync  out  1  active-low vertical sync, delayed by SYNC_DELAY ticks
line_start  out  1  one-clk pulse on the tick where x becomes 0
frame_start  out  1  one-clk pulse on the tick where (x,y) becomes (0,0)

Behaviour:
- Derived values: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). `width_log2 and `height_log2 must each be >= 10.
- Reset (asynchronous, on rst high):
  - div_cnt = 0; x = H_TOTAL-1; y = V_TOTAL-1.
  - toDisplay = 0, pixel_tick = 0, line_start = 0, frame_start = 0.
  - hsync = 1, vsync = 1, and every delay-line stage = 1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered and is high in the clk cycle after div_cnt == CLK_DIV-1.
  - With CLK_DIV = 1, pixel_tick is high every cycle after the first post-reset edge.
- Scan counters (advance only on an edge where the divider terminal count is reached; the same edge raises pixel_tick):
  - x increments. At x == H_TOTAL-1, x wraps to 0 and y increments.
  - At y == V_TOTAL-1 on that same wrap, y wraps to 0. Horizontal and vertical wrap happen in the same edge, with no extra cycle.
- Registered outputs, all updated on the same edge as x/y and consistent with the new x/y values (no skew between them):
  - toDisplay.
  - line_start: high for exactly one clk when the new x = 0.
  - frame_start: high for exactly one clk when the new (x,y) = (0,0).
  - Consequently the first tick after reset gives x=0, y=0, toDisplay=1, line_start=1, frame_start=1.
- Raw syncs:
  - hsync_raw = 0 iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync_raw = 0 iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- Delay line: shifts only on pixel ticks. hsync/vsync equal the raw values from SYNC_DELAY ticks earlier; SYNC_DELAY = 0 passes them through, registered.
- Between ticks, every output holds its value.
- Reset mid-frame: immediate return to reset values, with no partial pulses. Scanning resumes per the rules above after rst deasserts.
- Out-of-range parameters (CLK_DIV = 0, SYNC_DELAY > 7) are not supported. The simulation model stops with $fatal at elaboration.

Decomposition:
- Shared defines header (alongside `width_log2 and `height_log2):
  - the H/V timing constants;
  - H_TOTAL and V_TOTAL;
  - sync polarity constants (SYNC_ACTIVE = 0).
- One sub-module, sync_delay_line: parameter DEPTH, 2-bit data, shift enable, async reset value 2'b11. It is instantiated once for {hsync, vsync}.

Test Plan:
- Assert rst for 3 clks, then release -> during reset x=799, y=524, toDisplay=0, hsync=vsync=1. The first pixel_tick arrives 4 clks after release, with x=0, y=0, toDisplay=1, frame_start=1.
- Free-run with CLK_DIV=4 -> pixel_tick period is exactly 4 clks; x steps 0,1,2 per tick; toDisplay falls on the tick where x=640 and rises at x=0.
- Horizontal sync, SYNC_DELAY=2 -> hsync low on ticks where x=658..753 inclusive (96 ticks), high otherwise; line_start pulses once per 800 ticks.
- Line/frame wrap -> from (799,0) the next tick gives (0,1) with line_start=1, frame_start=0. From (799,524) the next tick gives (0,0) with both pulses 1. vsync is low for 1600 ticks starting at (2,490).
- CLK_DIV=1, SYNC_DELAY=0 -> pixel_tick is constantly 1 after the first edge; hsync falls at x=656 with no extra delay.
- Assert rst at (300,200) mid-tick -> outputs return to reset values in the same cycle. After release, the scan restarts at (0,0) with frame_start=1.
